// File: rtl/hazard_detect_unit_if.sv
// ID-stage hazard bundle: decoder-side instruction info in, forwarding selects
// and pipeline-register controls out.
interface hazard_detect_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic [REG_ADDR_W-1:0] rd_id;
    logic                  rs1use_id;
    logic                  rs2use_id;
    logic [1:0]            hazard_optype_id;
    logic                  Branch_ID;
    logic [1:0]            forward_ctrl_A;
    logic [1:0]            forward_ctrl_B;
    logic                  PC_EN_IF;
    logic                  reg_FD_EN;
    logic                  reg_FD_flush;
    logic                  reg_DE_flush;
    logic                  load_use_stall;

    modport master (
        output rs1_id, rs2_id, rd_id, rs1use_id, rs2use_id, hazard_optype_id, Branch_ID,
        input  forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_FD_EN, reg_FD_flush,
               reg_DE_flush, load_use_stall
    );

    modport slave (
        input  rs1_id, rs2_id, rd_id, rs1use_id, rs2use_id, hazard_optype_id, Branch_ID,
        output forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_FD_EN, reg_FD_flush,
               reg_DE_flush, load_use_stall
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Hazard unit for a 5-stage in-order core with branch resolution in ID:
// shadows EX/MEM destination info and drives ID forwarding, load-use stall and flushes.
module hazard_detect_unit #(
    parameter int REG_ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_detect_unit_if.slave hif
);
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    logic [1:0]            optype_ex_q, optype_ex_d;
    logic [REG_ADDR_W-1:0] rd_ex_q, rd_ex_d;
    logic [1:0]            optype_mem_q, optype_mem_d;
    logic [REG_ADDR_W-1:0] rd_mem_q, rd_mem_d;

    logic ex_alu_wr, mem_alu_wr, mem_ld_wr, ex_ld_wr;
    logic stall;

    // rd == 0 is never a writer, so x0 reads always come from the regfile.
    assign ex_alu_wr  = (optype_ex_q == OP_ALU)   && (rd_ex_q != '0);
    assign ex_ld_wr   = (optype_ex_q == OP_LOAD)  && (rd_ex_q != '0);
    assign mem_alu_wr = (optype_mem_q == OP_ALU)  && (rd_mem_q != '0);
    assign mem_ld_wr  = (optype_mem_q == OP_LOAD) && (rd_mem_q != '0);

    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r) begin
            if (ex_alu_wr && rs == rd_ex_q)        sel = 2'b01;
            else if (mem_alu_wr && rs == rd_mem_q) sel = 2'b10;
            else if (mem_ld_wr && rs == rd_mem_q)  sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        stall = ex_ld_wr &&
                ((hif.rs1use_id && hif.rs1_id == rd_ex_q) ||
                 (hif.rs2use_id && hif.rs2_id == rd_ex_q));
    end

    always_comb begin
        hif.forward_ctrl_A = fwd_sel(hif.rs1use_id, hif.rs1_id);
        hif.forward_ctrl_B = fwd_sel(hif.rs2use_id, hif.rs2_id);
        hif.load_use_stall = stall;
        hif.PC_EN_IF       = ~stall;
        hif.reg_FD_EN      = ~stall;
        hif.reg_DE_flush   = stall;
        // A branch seen during a stall compared stale operands; it re-resolves next cycle.
        hif.reg_FD_flush   = hif.Branch_ID & ~stall;
    end

    always_comb begin
        optype_mem_d = optype_ex_q;
        rd_mem_d     = rd_ex_q;
        optype_ex_d  = OP_NONE;
        rd_ex_d      = '0;
        if (!stall) begin
            optype_ex_d = (hif.hazard_optype_id == OP_STORE) ? OP_NONE : hif.hazard_optype_id;
            rd_ex_d     = hif.rd_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            optype_ex_q  <= OP_NONE;
            rd_ex_q      <= '0;
            optype_mem_q <= OP_NONE;
            rd_mem_q     <= '0;
        end else begin
            optype_ex_q  <= optype_ex_d;
            rd_ex_q      <= rd_ex_d;
            optype_mem_q <= optype_mem_d;
            rd_mem_q     <= rd_mem_d;
        end
    end
endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: one task per scenario, hand-computed expectations.
module tb_hazard_detect_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hazard_detect_unit_if #(.REG_ADDR_W(5)) hif ();

    hazard_detect_unit #(.REG_ADDR_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hif  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the ID-stage instruction and let combinational outputs settle.
    task automatic id_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [1:0] op, input logic br);
        hif.rs1_id = rs1; hif.rs2_id = rs2; hif.rd_id = rd;
        hif.rs1use_id = u1; hif.rs2use_id = u2;
        hif.hazard_optype_id = op; hif.Branch_ID = br;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++; if (hif.forward_ctrl_A !== 2'b00) begin errors++; $display("FAIL rst_fwdA got=%0d exp=0", hif.forward_ctrl_A); end
        checks++; if (hif.forward_ctrl_B !== 2'b00) begin errors++; $display("FAIL rst_fwdB got=%0d exp=0", hif.forward_ctrl_B); end
        checks++; if (hif.PC_EN_IF !== 1'b1) begin errors++; $display("FAIL rst_pc_en got=%0b exp=1", hif.PC_EN_IF); end
        checks++; if (hif.reg_FD_EN !== 1'b1) begin errors++; $display("FAIL rst_fd_en got=%0b exp=1", hif.reg_FD_EN); end
        checks++; if (hif.reg_FD_flush !== 1'b0 || hif.reg_DE_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b%0b exp=00", hif.reg_FD_flush, hif.reg_DE_flush); end
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", hif.load_use_stall); end
        step();
        rst_n = 1'b1;
        // lw x6 enters EX, then a consumer of x6 sees a stall
        id_in(5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        id_in(5'd2, 5'd6, 5'd9, 1'b1, 1'b1, 2'b01, 1'b0);
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%0b exp=1", hif.load_use_stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall got=%0b exp=0", hif.load_use_stall); end
        step();
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_held_stall got=%0b exp=0", hif.load_use_stall); end
        checks++; if (hif.forward_ctrl_A !== 2'b00 || hif.forward_ctrl_B !== 2'b00) begin errors++; $display("FAIL rst_held_fwd got=%0d/%0d exp=0/0", hif.forward_ctrl_A, hif.forward_ctrl_B); end
        rst_n = 1'b1;
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        step();
    endtask

    task automatic test_alu_chain();
        id_in(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 2'b01, 1'b0);   // add x5
        step();
        id_in(5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0);   // addi x8, x5
        checks++; if (hif.forward_ctrl_A !== 2'b01) begin errors++; $display("FAIL alu_ex_fwdA got=%0d exp=1", hif.forward_ctrl_A); end
        checks++; if (hif.forward_ctrl_B !== 2'b00) begin errors++; $display("FAIL alu_ex_fwdB got=%0d exp=0", hif.forward_ctrl_B); end
        step();
        id_in(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        checks++; if (hif.forward_ctrl_A !== 2'b10) begin errors++; $display("FAIL alu_mem_fwdA got=%0d exp=2", hif.forward_ctrl_A); end
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%0b exp=0", hif.load_use_stall); end
        step();
    endtask

    task automatic test_load_use();
        id_in(5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0);   // lw x6
        step();
        id_in(5'd2, 5'd6, 5'd9, 1'b1, 1'b1, 2'b01, 1'b0);   // add x9, x2, x6
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", hif.load_use_stall); end
        checks++; if (hif.PC_EN_IF !== 1'b0 || hif.reg_FD_EN !== 1'b0) begin errors++; $display("FAIL lu_enables got=%0b%0b exp=00", hif.PC_EN_IF, hif.reg_FD_EN); end
        checks++; if (hif.reg_DE_flush !== 1'b1) begin errors++; $display("FAIL lu_de_flush got=%0b exp=1", hif.reg_DE_flush); end
        step();
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle got=%0b exp=0", hif.load_use_stall); end
        checks++; if (hif.forward_ctrl_B !== 2'b11) begin errors++; $display("FAIL lu_fwdB got=%0d exp=3", hif.forward_ctrl_B); end
        checks++; if (hif.PC_EN_IF !== 1'b1 || hif.reg_DE_flush !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b%0b exp=10", hif.PC_EN_IF, hif.reg_DE_flush); end
        step();
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        step();
    endtask

    task automatic test_x0_priority();
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0);   // lw x0
        step();
        id_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b01, 1'b0);   // add x0, x0, x0
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%0b exp=0", hif.load_use_stall); end
        step();
        id_in(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0);   // reads x0 with ALU x0 in EX, load x0 in MEM
        checks++; if (hif.forward_ctrl_A !== 2'b00) begin errors++; $display("FAIL x0_fwdA got=%0d exp=0", hif.forward_ctrl_A); end
        step();
        id_in(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 2'b01, 1'b0);   // second writer of x7
        step();
        id_in(5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        checks++; if (hif.forward_ctrl_A !== 2'b01) begin errors++; $display("FAIL prio_fwdA got=%0d exp=1", hif.forward_ctrl_A); end
        checks++; if (hif.forward_ctrl_B !== 2'b01) begin errors++; $display("FAIL prio_fwdB got=%0d exp=1", hif.forward_ctrl_B); end
        step();
    endtask

    task automatic test_branch();
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        checks++; if (hif.reg_FD_flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%0b exp=1", hif.reg_FD_flush); end
        step();
        id_in(5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 2'b10, 1'b0);  // lw x10
        step();
        id_in(5'd10, 5'd3, 5'd0, 1'b1, 1'b1, 2'b00, 1'b1);  // beq x10, x3
        checks++; if (hif.reg_FD_flush !== 1'b0) begin errors++; $display("FAIL br_stall_flush got=%0b exp=0", hif.reg_FD_flush); end
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL br_stall got=%0b exp=1", hif.load_use_stall); end
        step();
        checks++; if (hif.reg_FD_flush !== 1'b1) begin errors++; $display("FAIL br_retry_flush got=%0b exp=1", hif.reg_FD_flush); end
        checks++; if (hif.forward_ctrl_A !== 2'b11) begin errors++; $display("FAIL br_retry_fwdA got=%0d exp=3", hif.forward_ctrl_A); end
        step();
        id_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        step();
    endtask

    task automatic test_unused_operand();
        id_in(5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 2'b10, 1'b0);  // lw x11
        step();
        id_in(5'd3, 5'd11, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        checks++; if (hif.load_use_stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%0b exp=0", hif.load_use_stall); end
        checks++; if (hif.forward_ctrl_B !== 2'b00) begin errors++; $display("FAIL unused_fwdB got=%0d exp=0", hif.forward_ctrl_B); end
        id_in(5'd3, 5'd11, 5'd0, 1'b1, 1'b1, 2'b11, 1'b0);  // sw x11, 0(x3)
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL store_data_stall got=%0b exp=1", hif.load_use_stall); end
        step();
        step();
    endtask

    task automatic test_store_no_write();
        id_in(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 2'b11, 1'b0);   // store with rd field = 5
        step();
        id_in(5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0);
        checks++; if (hif.forward_ctrl_A !== 2'b00) begin errors++; $display("FAIL store_ex_fwdA got=%0d exp=0", hif.forward_ctrl_A); end
        step();
        checks++; if (hif.forward_ctrl_B !== 2'b00) begin errors++; $display("FAIL store_mem_fwdB got=%0d exp=0", hif.forward_ctrl_B); end
        step();
    endtask

    task automatic test_back_to_back();
        id_in(5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0);  // lw x12
        step();
        id_in(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 2'b10, 1'b0); // lw x13, 0(x12)
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got=%0b exp=1", hif.load_use_stall); end
        step();
        checks++; if (hif.load_use_stall !== 1'b0 || hif.forward_ctrl_A !== 2'b11) begin errors++; $display("FAIL b2b_go1 got=%0b/%0d exp=0/3", hif.load_use_stall, hif.forward_ctrl_A); end
        step();
        id_in(5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 2'b01, 1'b0); // add x14, x13
        checks++; if (hif.load_use_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got=%0b exp=1", hif.load_use_stall); end
        step();
        checks++; if (hif.load_use_stall !== 1'b0 || hif.forward_ctrl_A !== 2'b11) begin errors++; $display("FAIL b2b_go2 got=%0b/%0d exp=0/3", hif.load_use_stall, hif.forward_ctrl_A); end
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0_priority();
        test_branch();
        test_unused_operand();
        test_store_no_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
